// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolution unit: funct3 codes,
// recovery FSM states and 2-bit saturating counter encodings.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } state_t;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Saturating step of a 2-bit direction counter
    function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken && ctr != ST) begin
            result = ctr + 2'd1;
        end else if (!taken && ctr != SNT) begin
            result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with a combinational
// read port for fetch and a single training port driven from EX.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rdIdx,
    output logic [1:0]       o_rdCtr,
    input  logic [IDX_W-1:0] i_wrIdx,
    input  logic             i_wrTaken,
    input  logic             i_wrEn
);

    logic [1:0] r_ctr [ENTRIES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= WNT;
            end
        end else if (i_wrEn) begin
            r_ctr[i_wrIdx] <= ctrNext(r_ctr[i_wrIdx], i_wrTaken);
        end
    end

    // Reads see the pre-update value when fetch and EX hit the same entry
    assign o_rdCtr = r_ctr[i_rdIdx];

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: direction decode, mispredict detection,
// redirect/flush generation, one-cycle recovery FSM, BHT training and counters.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    output logic        if_pred_taken_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_is_jump_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        br_unsigned_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_branchCnt;
    logic [31:0] r_mispredCnt;
    logic        w_condTaken;
    logic        w_validF3;
    logic        w_resolve;
    logic        w_condBranch;
    logic        w_actualTaken;
    logic        w_mispredict;
    logic        w_bhtUpdate;
    logic [1:0]  w_rdCtr;
    logic        w_unusedBits;

    assign br_unsigned_o = ex_funct3_i[1];

    always_comb begin
        w_condTaken = 1'b0;
        w_validF3   = 1'b1;
        case (ex_funct3_i)
            F3_BEQ:           w_condTaken = br_equal_i;
            F3_BNE:           w_condTaken = ~br_equal_i;
            F3_BLT, F3_BLTU:  w_condTaken = br_less_i;
            F3_BGE, F3_BGEU:  w_condTaken = ~br_less_i;
            default:          w_validF3   = 1'b0;
        endcase
    end

    // Reset gates resolution so redirect/flush stay low while it is held
    assign w_resolve     = ~rst_i & ex_valid_i & (ex_is_branch_i | ex_is_jump_i)
                           & (r_state == NORMAL);
    assign w_condBranch  = ex_is_branch_i & ~ex_is_jump_i;
    assign w_actualTaken = ex_is_jump_i | (w_condBranch & w_validF3 & w_condTaken);
    assign w_mispredict  = w_resolve
                           & ((w_actualTaken != ex_pred_taken_i)
                              | (w_actualTaken & ex_pred_taken_i
                                 & (ex_pred_target_i != ex_target_i)));
    assign w_bhtUpdate   = w_resolve & w_condBranch & w_validF3;

    assign redirect_o    = w_mispredict;
    assign flush_o       = w_mispredict;
    assign redirect_pc_o = !w_mispredict ? 32'd0
                         : (w_actualTaken ? ex_target_i : ex_pc_i + 32'd4);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // One dead cycle after a mispredict lets the wrong-path EX op drain
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            NORMAL:  if (w_mispredict) w_nextState = RECOVER;
            RECOVER: w_nextState = NORMAL;
            default: w_nextState = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_branchCnt  <= 32'd0;
            r_mispredCnt <= 32'd0;
        end else begin
            if (w_bhtUpdate) begin
                r_branchCnt <= r_branchCnt + 32'd1;
            end
            if (w_mispredict) begin
                r_mispredCnt <= r_mispredCnt + 32'd1;
            end
        end
    end

    assign branch_cnt_o  = r_branchCnt;
    assign mispred_cnt_o = r_mispredCnt;

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX)
    ) u_bht (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_rdIdx   (if_pc_i[IDX+1:2]),
        .o_rdCtr   (w_rdCtr),
        .i_wrIdx   (ex_pc_i[IDX+1:2]),
        .i_wrTaken (w_condTaken),
        .i_wrEn    (w_bhtUpdate)
    );

    assign if_pred_taken_o = w_rdCtr[1];

    assign w_unusedBits = ^{if_pc_i[31:IDX+2], if_pc_i[1:0], w_rdCtr[0]};

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios then random
// traffic, compared against an operand-level reference model.
module tb_branch_resolve;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic        if_pred_taken_o;
    logic        ex_valid_i = 1'b0;
    logic        ex_is_branch_i = 1'b0;
    logic        ex_is_jump_i = 1'b0;
    logic [2:0]  ex_funct3_i = '0;
    logic [31:0] ex_pc_i = '0;
    logic [31:0] ex_target_i = '0;
    logic        ex_pred_taken_i = 1'b0;
    logic [31:0] ex_pred_target_i = '0;
    logic        br_less_i = 1'b0;
    logic        br_equal_i = 1'b0;
    logic        br_unsigned_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          bhtModel [16];
    logic [31:0] branchCnt;
    logic [31:0] mispredCnt;
    bit          inRecover;

    branch_resolve #(.BHT_ENTRIES(16)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .if_pc_i          (if_pc_i),
        .if_pred_taken_o  (if_pred_taken_o),
        .ex_valid_i       (ex_valid_i),
        .ex_is_branch_i   (ex_is_branch_i),
        .ex_is_jump_i     (ex_is_jump_i),
        .ex_funct3_i      (ex_funct3_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .br_less_i        (br_less_i),
        .br_equal_i       (br_equal_i),
        .br_unsigned_o    (br_unsigned_o),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Holds reset (with a would-be mispredicting jump on EX) and sweeps fetch PCs
    task automatic resetCheck();
        rst_i            = 1'b1;
        ex_valid_i       = 1'b1;
        ex_is_branch_i   = 1'b0;
        ex_is_jump_i     = 1'b1;
        ex_funct3_i      = 3'b000;
        ex_pc_i          = 32'h0000_0500;
        ex_target_i      = 32'h0000_0900;
        ex_pred_taken_i  = 1'b0;
        ex_pred_target_i = 32'd0;
        #1;
        checkOutput("rst_redirect", {31'd0, redirect_o}, 32'd0);
        checkOutput("rst_flush", {31'd0, flush_o}, 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc_o, 32'd0);
        checkOutput("rst_unsigned", {31'd0, br_unsigned_o}, 32'd0);
        checkOutput("rst_branch_cnt", branch_cnt_o, 32'd0);
        checkOutput("rst_mispred_cnt", mispred_cnt_o, 32'd0);
        for (int k = 0; k < 16; k++) begin
            if_pc_i = {$urandom_range(0, 255), 20'd0, 4'(k), 2'b00};
            #1;
            checkOutput("rst_pred", {31'd0, if_pred_taken_o}, 32'd0);
        end
        for (int k = 0; k < 16; k++) bhtModel[k] = 1;
        branchCnt  = '0;
        mispredCnt = '0;
        inRecover  = 1'b0;
        @(negedge clk_i);
        rst_i      = 1'b0;
        ex_valid_i = 1'b0;
    endtask

    // One EX cycle: drive at negedge, check combinational outputs, advance model at posedge
    task automatic applyStimulus(input string tag, input logic valid, input logic isBr,
                                 input logic isJmp, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] target,
                                 input logic predT, input logic [31:0] predTgt,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] ifPc);
        bit          taken;
        bit          knownF3;
        bit          resolve;
        bit          actual;
        bit          mis;
        logic [31:0] expPc;
        int          idx;

        br_equal_i = (rs1 == rs2);
        br_less_i  = f3[1] ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

        knownF3 = 1'b1;
        case (f3)
            3'd0:    taken = (rs1 == rs2);
            3'd1:    taken = (rs1 != rs2);
            3'd4:    taken = ($signed(rs1) <  $signed(rs2));
            3'd5:    taken = ($signed(rs1) >= $signed(rs2));
            3'd6:    taken = (rs1 <  rs2);
            3'd7:    taken = (rs1 >= rs2);
            default: begin taken = 1'b0; knownF3 = 1'b0; end
        endcase

        ex_valid_i       = valid;
        ex_is_branch_i   = isBr;
        ex_is_jump_i     = isJmp;
        ex_funct3_i      = f3;
        ex_pc_i          = pc;
        ex_target_i      = target;
        ex_pred_taken_i  = predT;
        ex_pred_target_i = predTgt;
        if_pc_i          = ifPc;
        #1;

        resolve = valid && (isBr || isJmp) && !inRecover;
        actual  = isJmp ? 1'b1 : (knownF3 && taken);
        mis     = resolve && ((actual != predT) || (actual && predT && predTgt != target));
        expPc   = mis ? (actual ? target : pc + 32'd4) : 32'd0;

        checkOutput({tag, "_redirect"}, {31'd0, redirect_o}, {31'd0, mis});
        checkOutput({tag, "_flush"}, {31'd0, flush_o}, {31'd0, mis});
        checkOutput({tag, "_redirect_pc"}, redirect_pc_o, expPc);
        checkOutput({tag, "_unsigned"}, {31'd0, br_unsigned_o}, {31'd0, f3[1]});
        checkOutput({tag, "_pred"}, {31'd0, if_pred_taken_o},
                    {31'd0, bhtModel[ifPc[5:2]] >= 2});
        checkOutput({tag, "_branch_cnt"}, branch_cnt_o, branchCnt);
        checkOutput({tag, "_mispred_cnt"}, mispred_cnt_o, mispredCnt);

        @(posedge clk_i);
        if (resolve && isBr && !isJmp && knownF3) begin
            branchCnt++;
            idx = pc[5:2];
            if (taken) bhtModel[idx] = (bhtModel[idx] == 3) ? 3 : bhtModel[idx] + 1;
            else       bhtModel[idx] = (bhtModel[idx] == 0) ? 0 : bhtModel[idx] - 1;
        end
        if (mis) mispredCnt++;
        inRecover = mis;
        @(negedge clk_i);
    endtask

    task automatic idleCycle(input logic [31:0] ifPc);
        applyStimulus("idle", 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h0,
                      32'd0, 32'd0, ifPc);
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] rPc;
        logic [31:0] rTgt;
        logic [2:0]  rF3;

        resetCheck();

        applyStimulus("blt_signed", 1'b1, 1'b1, 1'b0, 3'b100, 32'h100, 32'h80, 1'b0, 32'h0,
                      -32'sd5, 32'd3, 32'h100);
        idleCycle(32'h100);

        applyStimulus("bgeu_nt", 1'b1, 1'b1, 1'b0, 3'b111, 32'h20, 32'h60, 1'b0, 32'h0,
                      32'd1, 32'd2, 32'h20);
        idleCycle(32'h20);

        applyStimulus("beq_sat0", 1'b1, 1'b1, 1'b0, 3'b000, 32'h40, 32'h400, 1'b0, 32'h0,
                      32'd7, 32'd7, 32'h40);
        idleCycle(32'h40);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("beq_sat", 1'b1, 1'b1, 1'b0, 3'b000, 32'h40, 32'h400, 1'b1,
                          32'h400, 32'd7, 32'd7, 32'h40);
        end
        idleCycle(32'h40);

        applyStimulus("bne_wrap", 1'b1, 1'b1, 1'b0, 3'b001, 32'hFFFF_FFFC, 32'h10, 1'b1,
                      32'h10, 32'd9, 32'd9, 32'hFFFF_FFFC);
        applyStimulus("recover_ignore", 1'b1, 1'b0, 1'b1, 3'b000, 32'h30, 32'h700, 1'b0,
                      32'h0, 32'd0, 32'd0, 32'h30);
        idleCycle(32'h30);

        applyStimulus("jalr_tgt", 1'b1, 1'b0, 1'b1, 3'b000, 32'h300, 32'h204, 1'b1,
                      32'h200, 32'd0, 32'd0, 32'h300);
        idleCycle(32'h300);
        applyStimulus("f3_010", 1'b1, 1'b1, 1'b0, 3'b010, 32'h44, 32'h90, 1'b0, 32'h0,
                      32'd1, 32'd2, 32'h44);
        applyStimulus("f3_011", 1'b1, 1'b1, 1'b0, 3'b011, 32'h44, 32'h90, 1'b0, 32'h0,
                      32'd5, 32'd5, 32'h44);

        for (int n = 0; n < 400; n++) begin
            r1 = $urandom_range(0, 3);
            r2 = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) r1 = ~r1;
            if ($urandom_range(0, 1) == 1) r2 = ~r2;
            rF3  = 3'($urandom_range(0, 7));
            rPc  = {$urandom_range(0, 1) == 1 ? 24'hFFFFFF : 24'h0, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
            rTgt = {$urandom_range(0, 255), 8'h00, 16'($urandom_range(0, 3) * 4)};
            applyStimulus("rand", 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 5) == 0), rF3, rPc, rTgt,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? rTgt + 32'd4 : rTgt,
                          r1, r2, {24'($urandom), 4'($urandom_range(0, 15)), 2'b00});
            if (n == 200) resetCheck();
        end

        applyStimulus("pre_rst_mis", 1'b1, 1'b0, 1'b1, 3'b000, 32'h80, 32'hC0, 1'b0, 32'h0,
                      32'd0, 32'd0, 32'h80);
        resetCheck();
        applyStimulus("post_rst_mis", 1'b1, 1'b0, 1'b1, 3'b000, 32'h84, 32'hC4, 1'b0, 32'h0,
                      32'd0, 32'd0, 32'h84);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution and direction-prediction unit for the RV32I pipeline. Consumes the branch comparator flags (`br_less`, `br_equal`), drives the comparator's signedness select, decides taken/not-taken per funct3, detects mispredictions against the fetch-time prediction, issues redirect and flush to IF/ID and ID/EX, and trains a 2-bit saturating branch history table (BHT) whose lookup serves the fetch stage.

## Interface

Parameters:
- `BHT_ENTRIES`, 16, number of 2-bit counters; power of two, ≥2; index = `pc[IDX+1:2]`, IDX = log2(BHT_ENTRIES)

Ports:
- `clk_i` input 1 — single clock, rising edge
- `rst_i` input 1 — asynchronous, active-high reset
- `if_pc_i` input 32 — fetch PC for BHT lookup
- `if_pred_taken_o` output 1 — predicted direction for `if_pc_i`
- `ex_valid_i` input 1 — EX stage holds a real instruction
- `ex_is_branch_i` input 1 — conditional branch (B-type)
- `ex_is_jump_i` input 1 — JAL/JALR
- `ex_funct3_i` input 3 — branch funct3
- `ex_pc_i` input 32 — PC of EX instruction
- `ex_target_i` input 32 — computed taken target
- `ex_pred_taken_i` input 1 — prediction carried from fetch
- `ex_pred_target_i` input 32 — target fetch used when predicted taken
- `br_less_i`, `br_equal_i` input 1 each — comparator flags
- `br_unsigned_o` output 1 — comparator signedness select
- `redirect_o` output 1 — PC must be overridden
- `redirect_pc_o` output 32 — corrected PC
- `flush_o` output 1 — clear IF/ID and ID/EX
- `branch_cnt_o` output 32 — resolved conditional branches
- `mispred_cnt_o` output 32 — mispredictions (branches and jumps)

## Operation

- `br_unsigned_o = ex_funct3_i[1]`, combinational, always driven.
- Condition: 000 BEQ = eq; 001 BNE = ~eq; 100 BLT, 110 BLTU = less; 101 BGE, 111 BGEU = ~less; 010/011 → not taken, no BHT update, not counted.
- Jumps: actual_taken = 1 regardless of flags.
- resolve = `ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & state==NORMAL`.
- Mispredict (when resolve): `actual_taken != ex_pred_taken_i`, or both taken and `ex_pred_target_i != ex_target_i`.
- On mispredict: `redirect_o = flush_o = 1`; `redirect_pc_o = ex_target_i` if actual_taken, else `ex_pc_i + 4` (32-bit wrap). Otherwise `redirect_o = flush_o = 0`, `redirect_pc_o = 0`.
- FSM: NORMAL → RECOVER on mispredict; RECOVER → NORMAL unconditionally next cycle. In RECOVER all EX inputs are ignored (no redirect, no update, no count).
- BHT: counters 00..11; predict taken = bit[1]. On resolved valid-funct3 conditional branch: taken → +1 saturating at 11, not-taken → −1 saturating at 00. Jumps never update.
- Counters: `branch_cnt_o` +1 per resolved valid-funct3 conditional branch; `mispred_cnt_o` +1 per mispredict; both wrap at 2^32.

## Timing

- Redirect, flush and `br_unsigned_o` are combinational in the resolve cycle N; the pipeline samples them at edge N→N+1.
- BHT writes, counters and state update at the same edge; visible in cycle N+1.
- `if_pred_taken_o` is a combinational read. Same-cycle read and write to one index returns the old value (no bypass).
- Reset (async, any time, including mid-RECOVER): state = NORMAL, all BHT entries = 01 (weakly not-taken), both counters = 0, so `if_pred_taken_o` = 0 and `redirect_o`/`flush_o` = 0 while `rst_i` is high.
- `ex_valid_i` = 0 → no effect regardless of other inputs.

## Structure

- `branch_pkg`: funct3 localparams (BEQ…BGEU), state enum {NORMAL, RECOVER}, 2-bit counter constants (SNT=00, WNT=01, WT=10, ST=11).
- Sub-module `bht_2bit`: counter array with combinational read port, one update port (index, taken, enable), async reset to WNT.
- Top: condition decode, mispredict compare, FSM, perf counters.

## Test plan

- Reset: assert `rst_i` mid-run → all outputs 0; lookup of any PC returns `if_pred_taken_o` = 0; counters read 0.
- BLT signed: rs flags less=1 via funct3 100, pred 0, pc 0x100, target 0x80 → `redirect_o`=1, `redirect_pc_o`=0x80, `flush_o`=1, `br_unsigned_o`=0, mispred_cnt=1.
- BGEU correct not-taken: funct3 111, less=1, pred 0 → no redirect; branch_cnt +1; BHT[pc] goes 01→00.
- Saturation: four taken BEQ at pc 0x40 → counter 01→10→11→11; first redirects to target, predicted-taken afterwards (pred=1, matching target) → no redirect.
- Predicted taken but not taken: BNE eq=1, pred 1, pc 0xFFFFFFFC → `redirect_pc_o`=0x00000000 (wrap); following cycle with ex_valid=1 is ignored (RECOVER).
- JALR with pred 1 and `ex_pred_target_i` 0x200 ≠ target 0x204 → redirect to 0x204, BHT unchanged, branch_cnt unchanged; funct3 010 branch → no action.
